// File: rtl/regfile_mp_if.sv
// Register-file bus: two write ports, reserve port, packed read ports, conflict status.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   we3;
    logic [AW-1:0]          wa3;
    logic [WIDTH-1:0]       wd3;
    logic                   we4;
    logic [AW-1:0]          wa4;
    logic [WIDTH-1:0]       wd4;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rd_busy;
    logic                   rsv;
    logic [AW-1:0]          rsv_addr;
    logic                   wr_conflict;
    logic                   conflict_clr;

    modport master (
        output we3, wa3, wd3, we4, wa4, wd4, ra, rsv, rsv_addr, conflict_clr,
        input  rd, rd_busy, wr_conflict
    );

    modport slave (
        input  we3, wa3, wd3, we4, wa4, wd4, ra, rsv, rsv_addr, conflict_clr,
        output rd, rd_busy, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port B wins collisions), NREAD combinational
// read ports with optional same-cycle forwarding, and a per-register busy scoreboard.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] memQ [DEPTH];
    logic [DEPTH-1:0] busyQ, busyD;
    logic             conflictQ;

    logic wrA, wrB, rsvOk, conflictSet;
    logic [NREAD*WIDTH-1:0] rdAll;
    logic [NREAD-1:0]       busyAll;

    // Address is backed by a real, non-hardwired register.
    function automatic logic live(logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    // Qualify write/reserve requests; dead addresses are silently dropped.
    always_comb begin
        wrA         = bus.we3 && live(bus.wa3);
        wrB         = bus.we4 && live(bus.wa4);
        rsvOk       = bus.rsv && live(bus.rsv_addr);
        conflictSet = wrA && wrB && (bus.wa3 == bus.wa4);
    end

    // Busy next-state: writes retire a pending producer, a reserve in the same cycle wins.
    always_comb begin
        busyD = busyQ;
        if (wrA) busyD[bus.wa3] = 1'b0;
        if (wrB) busyD[bus.wa4] = 1'b0;
        if (rsvOk) busyD[bus.rsv_addr] = 1'b1;
    end

    // Storage, scoreboard and sticky conflict flag; port B is written last so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) memQ[i] <= '0;
            busyQ     <= '0;
            conflictQ <= 1'b0;
        end else begin
            if (wrA) memQ[bus.wa3] <= bus.wd3;
            if (wrB) memQ[bus.wa4] <= bus.wd4;
            busyQ <= busyD;
            if (conflictSet)           conflictQ <= 1'b1;
            else if (bus.conflict_clr) conflictQ <= 1'b0;
        end
    end

    // Independent read ports; forwarded write data also hides the busy bit it retires.
    always_comb begin
        logic [AW-1:0] addr;
        rdAll   = '0;
        busyAll = '0;
        for (int i = 0; i < NREAD; i++) begin
            addr = bus.ra[i*AW +: AW];
            if (rst_n && live(addr)) begin
                rdAll[i*WIDTH +: WIDTH] = memQ[addr];
                busyAll[i]              = busyQ[addr];
                if (BYPASS) begin
                    if (wrB && (bus.wa4 == addr)) begin
                        rdAll[i*WIDTH +: WIDTH] = bus.wd4;
                        busyAll[i]              = 1'b0;
                    end else if (wrA && (bus.wa3 == addr)) begin
                        rdAll[i*WIDTH +: WIDTH] = bus.wd3;
                        busyAll[i]              = 1'b0;
                    end
                end
            end
        end
    end

    assign bus.rd          = rdAll;
    assign bus.rd_busy     = busyAll;
    assign bus.wr_conflict = conflictQ;
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of registers; AW = clog2(DEPTH).
REQ-003 SHALL provide parameter NREAD, default 2, number of independent read ports (1..8).
REQ-004 SHALL provide parameter BYPASS, default 1: 1 = same-cycle write data forwarded to reads, 0 = reads see stored value only.
REQ-005 SHALL provide parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.

Interface
REQ-006 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have: we3  input  1  write enable, port A.
REQ-009 SHALL have: wa3  input  AW  write address, port A.
REQ-010 SHALL have: wd3  input  WIDTH  write data, port A.
REQ-011 SHALL have: we4  input  1  write enable, port B.
REQ-012 SHALL have: wa4  input  AW  write address, port B.
REQ-013 SHALL have: wd4  input  WIDTH  write data, port B.
REQ-014 SHALL have: ra  input  NREAD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-015 SHALL have: rd  output  NREAD*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH].
REQ-016 SHALL have: rd_busy  output  NREAD  per-read-port busy flag of addressed register.
REQ-017 SHALL have: rsv  input  1  reserve request (mark register busy, pending producer).
REQ-018 SHALL have: rsv_addr  input  AW  register to reserve.
REQ-019 SHALL have: wr_conflict  output  1  sticky flag, both write ports hit same address in one cycle.
REQ-020 SHALL have: conflict_clr  input  1  synchronous clear of wr_conflict.

Function
REQ-021 SHALL write wd3 to reg[wa3] at rising clk when we3=1; likewise wd4 to reg[wa4] when we4=1.
REQ-022 SHALL, when we3=we4=1 and wa3==wa4, store wd4 only (port B priority) and set wr_conflict at that edge.
REQ-023 SHALL hold wr_conflict at 1 until a cycle with conflict_clr=1; a new conflict in the same cycle as conflict_clr leaves it 1 (set wins).
REQ-024 SHALL drive rd port i combinationally from reg[ra_i], zero read latency.
REQ-025 SHALL, with BYPASS=1, forward wd4 if we4 and wa4==ra_i, else wd3 if we3 and wa3==ra_i, else stored value.
REQ-026 SHALL, with ZERO_REG=1, return 0 for reads of address 0, ignore writes and reserves to address 0, never flag conflict on address 0.
REQ-027 SHALL ignore writes/reserves to addresses >= DEPTH and return 0 on reads of such addresses.
REQ-028 SHALL keep one busy bit per register: set at edge when rsv=1, cleared at edge when either write port writes that register.
REQ-029 SHALL, when reserve and write target the same register in one cycle, leave busy=1 (reserve wins; newer producer pending).
REQ-030 SHALL drive rd_busy[i] = busy[ra_i], except with BYPASS=1 it reads 0 when a same-cycle write to ra_i is present.
REQ-031 SHALL keep all read ports fully independent; any ports may address the same register.

Reset
REQ-032 SHALL, on rst_n=0, immediately (no clock) clear all registers to 0, all busy bits to 0, wr_conflict to 0.
REQ-033 SHALL ignore writes, reserves and conflict_clr while rst_n=0; a write in the cycle rst_n deasserts takes effect at the next rising edge.
REQ-034 SHALL drive rd = 0 and rd_busy = 0 on all ports during reset.

Verification
REQ-035 Reset mid-operation: write 0xDEADBEEF to r5, pulse rst_n low between edges -> rd(ra=5) = 0 immediately, busy and wr_conflict 0.
REQ-036 Dual write distinct: we3 wa3=2 wd3=12, we4 wa4=3 wd4=7 -> next cycle r2=12, r3=7, wr_conflict=0.
REQ-037 Collision: we3 wa3=4 wd3=0x11, we4 wa4=4 wd4=0x22 -> r4=0x22, wr_conflict=1 sticky until conflict_clr; clr with no conflict -> 0.
REQ-038 Bypass: BYPASS=1, r6=1, same cycle we3 wa3=6 wd3=9 with ra0=6 -> rd0=9 before edge; BYPASS=0 -> rd0=1 until edge.
REQ-039 Zero reg: we3 wa3=0 wd3=0xFFFFFFFF, rsv addr 0 -> rd(ra=0)=0, rd_busy=0, no conflict on dual write to 0.
REQ-040 Scoreboard: rsv r10 -> rd_busy=1 next cycle; same-cycle rsv r10 and write r10 -> busy stays 1; plain write r10 -> rd_busy=0, data visible.
